// File: rtl/md_unit_if.sv
// md_unit_if: request/result bundle between the EX stage and the multiply/divide unit.
//   start    - one-cycle request, qualified by md_op
//   md_op    - 0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=no-op
//   rs_data  - multiplicand / dividend / MTHI-MTLO source
//   rt_data  - multiplier / divisor
//   out_sel  - 0 reads LO, 1 reads HI on md_out
//   md_out   - combinational HI/LO read mux
//   busy     - multiply/divide in flight
//   hi, lo   - architectural HI/LO registers
interface md_unit_if;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        out_sel;
   logic [31:0] md_out;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   // Pipeline side: issues requests and reads results.
   modport master (
      output start, md_op, rs_data, rt_data, out_sel,
      input  md_out, busy, hi, lo
   );

   // Unit side.
   modport slave (
      input  start, md_op, rs_data, rt_data, out_sel,
      output md_out, busy, hi, lo
   );
endinterface

// File: rtl/md_unit.sv
// md_unit: MIPS EX-stage multiply/divide unit owning HI/LO.
//   clk    - clock
//   reset  - synchronous active-high reset (clears HI/LO, aborts any operation)
//   md     - md_unit_if.slave: start/md_op/rs_data/rt_data/out_sel in,
//            md_out/busy/hi/lo out
// The 64-bit result is computed at the accept edge into pending registers;
// busy then models the latency and HI/LO are updated on the edge busy falls.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic      clk,
   input  logic      reset,
   md_unit_if.slave  md
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam int unsigned OP_W       = 3;
   localparam int unsigned DATA_W     = 32;

   localparam logic [OP_W-1:0]  OP_DIVU   = OP_W'(3);
   localparam logic [OP_W-1:0]  OP_MTHI   = OP_W'(4);
   localparam logic [OP_W-1:0]  OP_MTLO   = OP_W'(5);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } stateType;

   stateType            state, stateNext;
   logic [CNT_W-1:0]    count, countNext;
   logic [DATA_W-1:0]   pendHi, pendHiNext;
   logic [DATA_W-1:0]   pendLo, pendLoNext;
   logic                pendWrite, pendWriteNext;
   logic [DATA_W-1:0]   hiReg, hiNext;
   logic [DATA_W-1:0]   loReg, loNext;
   logic                busyReg, busyNext;

   // Request decode: only honoured while idle.
   logic isIdle, acceptMd, acceptMtHi, acceptMtLo, isDiv, isSigned, divByZero;
   assign isIdle     = (state == IDLE);
   assign acceptMd   = md.start && isIdle && (md.md_op <= OP_DIVU);
   assign acceptMtHi = md.start && isIdle && (md.md_op == OP_MTHI);
   assign acceptMtLo = md.start && isIdle && (md.md_op == OP_MTLO);
   assign isDiv      = md.md_op[1];
   assign isSigned   = ~md.md_op[0];
   assign divByZero  = (md.rt_data == '0);

   // Arithmetic on the operands presented at the accept edge.
   logic [2*DATA_W-1:0] mulA, mulB, product;
   logic [DATA_W-1:0]   divisorSafe, absA, absB, quotMag, remMag, quotient, remainder;
   logic                negA, negB;

   always_comb begin
      mulA = isSigned ? {{DATA_W{md.rs_data[DATA_W-1]}}, md.rs_data} : {{DATA_W{1'b0}}, md.rs_data};
      mulB = isSigned ? {{DATA_W{md.rt_data[DATA_W-1]}}, md.rt_data} : {{DATA_W{1'b0}}, md.rt_data};
      // Low 64 bits of the sign/zero-extended product equal the exact product.
      product = mulA * mulB;

      // Signed divide via magnitudes: quotient truncates toward zero,
      // remainder takes the dividend's sign. -2^31 / -1 wraps to 0x80000000.
      divisorSafe = divByZero ? DATA_W'(1) : md.rt_data;
      negA        = isSigned && md.rs_data[DATA_W-1];
      negB        = isSigned && divisorSafe[DATA_W-1];
      absA        = negA ? (DATA_W'(0) - md.rs_data) : md.rs_data;
      absB        = negB ? (DATA_W'(0) - divisorSafe) : divisorSafe;
      quotMag     = absA / absB;
      remMag      = absA % absB;
      quotient    = (negA ^ negB) ? (DATA_W'(0) - quotMag) : quotMag;
      remainder   = negA ? (DATA_W'(0) - remMag) : remMag;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (acceptMd)         stateNext = BUSY;
         BUSY:    if (count == CNT_ONE) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Output / datapath next values.
   always_comb begin
      countNext     = count;
      pendHiNext    = pendHi;
      pendLoNext    = pendLo;
      pendWriteNext = pendWrite;
      hiNext        = hiReg;
      loNext        = loReg;
      busyNext      = busyReg;
      case (state)
         IDLE: begin
            if (acceptMd) begin
               busyNext = 1'b1;
               if (isDiv) begin
                  countNext     = DIV_LOAD;
                  pendHiNext    = remainder;
                  pendLoNext    = quotient;
                  // Divide by zero still occupies the unit but leaves HI/LO alone.
                  pendWriteNext = ~divByZero;
               end else begin
                  countNext     = MULT_LOAD;
                  pendHiNext    = product[2*DATA_W-1:DATA_W];
                  pendLoNext    = product[DATA_W-1:0];
                  pendWriteNext = 1'b1;
               end
            end else if (acceptMtHi) begin
               hiNext = md.rs_data;
            end else if (acceptMtLo) begin
               loNext = md.rs_data;
            end
         end
         BUSY: begin
            countNext = count - CNT_ONE;
            if (count == CNT_ONE) begin
               busyNext = 1'b0;
               if (pendWrite) begin
                  hiNext = pendHi;
                  loNext = pendLo;
               end
            end
         end
         default: begin
            busyNext = 1'b0;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= '0;
         pendHi    <= '0;
         pendLo    <= '0;
         pendWrite <= 1'b0;
         hiReg     <= '0;
         loReg     <= '0;
         busyReg   <= 1'b0;
      end else begin
         count     <= countNext;
         pendHi    <= pendHiNext;
         pendLo    <= pendLoNext;
         pendWrite <= pendWriteNext;
         hiReg     <= hiNext;
         loReg     <= loNext;
         busyReg   <= busyNext;
      end
   end

   assign md.busy   = busyReg;
   assign md.hi     = hiReg;
   assign md.lo     = loReg;
   // MFHI/MFLO read path; no bypass of in-flight results.
   assign md.md_out = md.out_sel ? hiReg : loReg;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit. Directed vector table, hand
// sequences for ignore-while-busy and mid-operation reset, and randomized
// operations checked against an arithmetic reference model.
module tb_md_unit;

   localparam int unsigned MULT_N = 5;
   localparam int unsigned DIV_N  = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   md_unit_if mdIf();

   md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (mdIf.slave)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vecT;

   int checks = 0;
   int errors = 0;
   logic [31:0] curHi, curLo;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural definition.
   function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] oldHi, input logic [31:0] oldLo,
                                    output logic [31:0] nHi, output logic [31:0] nLo, output int cyc);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      nHi = oldHi;
      nLo = oldLo;
      cyc = 0;
      case (op)
         3'd0: begin p = 64'(sa * sb); nHi = p[63:32]; nLo = p[31:0]; cyc = MULT_N; end
         3'd1: begin p = {32'b0, a} * {32'b0, b}; nHi = p[63:32]; nLo = p[31:0]; cyc = MULT_N; end
         3'd2: begin
            cyc = DIV_N;
            if (b != 0) begin
               q = sa / sb; r = sa % sb;
               p = 64'(q); nLo = p[31:0];
               p = 64'(r); nHi = p[31:0];
            end
         end
         3'd3: begin
            cyc = DIV_N;
            if (b != 0) begin nLo = a / b; nHi = a % b; end
         end
         3'd4: nHi = a;
         3'd5: nLo = a;
         default: ;
      endcase
   endfunction

   // Issue one request, verify busy length, HI/LO hold during busy, final HI/LO and md_out.
   task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] exHi, input logic [31:0] exLo, input int exCyc);
      int n;
      @(negedge clk);
      mdIf.start   = 1'b1;
      mdIf.md_op   = op;
      mdIf.rs_data = rs;
      mdIf.rt_data = rt;
      @(negedge clk);
      mdIf.start   = 1'b0;
      mdIf.md_op   = 3'($urandom);
      mdIf.rs_data = $urandom;
      mdIf.rt_data = $urandom;
      n = 0;
      while (mdIf.busy && n < 40) begin
         n++;
         check({name, " hold hi"}, mdIf.hi, curHi);
         check({name, " hold lo"}, mdIf.lo, curLo);
         @(negedge clk);
      end
      check({name, " busy cycles"}, 32'(n), 32'(exCyc));
      check({name, " hi"}, mdIf.hi, exHi);
      check({name, " lo"}, mdIf.lo, exLo);
      curHi = exHi;
      curLo = exLo;
      mdIf.out_sel = 1'b0;
      #1 check({name, " md_out lo"}, mdIf.md_out, exLo);
      mdIf.out_sel = 1'b1;
      #1 check({name, " md_out hi"}, mdIf.md_out, exHi);
   endtask

   vecT vecs[10];

   initial begin
      int          n, cyc;
      logic [2:0]  op;
      logic [31:0] a, b, eHi, eLo;

      vecs[0] = '{3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
      vecs[1] = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
      vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[3] = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
      vecs[4] = '{3'd4, 32'h00000011, 32'h00000000, 32'h00000011, 32'h00000003, 0};
      vecs[5] = '{3'd5, 32'h00000022, 32'h00000000, 32'h00000011, 32'h00000022, 0};
      vecs[6] = '{3'd3, 32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022, 10};
      vecs[7] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
      vecs[8] = '{3'd6, 32'h12345678, 32'h00000003, 32'h00000000, 32'h80000000, 0};
      vecs[9] = '{3'd7, 32'h9ABCDEF0, 32'h00000005, 32'h00000000, 32'h80000000, 0};

      reset        = 1'b1;
      mdIf.start   = 1'b0;
      mdIf.md_op   = 3'd6;
      mdIf.rs_data = '0;
      mdIf.rt_data = '0;
      mdIf.out_sel = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset busy", 32'(mdIf.busy), 32'd0);
      check("reset hi", mdIf.hi, 32'd0);
      check("reset lo", mdIf.lo, 32'd0);
      check("reset md_out", mdIf.md_out, 32'd0);
      curHi = '0;
      curLo = '0;

      for (int i = 0; i < 10; i++)
         runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo, vecs[i].cyc);

      // Requests during busy (MTHI then DIV) are dropped; MULT completes unchanged.
      @(negedge clk);
      mdIf.start = 1'b1; mdIf.md_op = 3'd0; mdIf.rs_data = 32'd3; mdIf.rt_data = 32'd7;
      n = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (mdIf.busy) n++;
         mdIf.start   = (c == 2) || (c == 3);
         mdIf.md_op   = (c == 2) ? 3'd4 : 3'd2;
         mdIf.rs_data = (c == 2) ? 32'hDEAD : 32'd100;
         mdIf.rt_data = 32'd3;
      end
      mdIf.start = 1'b0;
      check("ignore busy cycles", 32'(n), 32'd5);
      check("ignore hi", mdIf.hi, 32'd0);
      check("ignore lo", mdIf.lo, 32'd21);

      // Reset in the middle of a MULT, with an MTHI attempted while busy.
      @(negedge clk);
      mdIf.start = 1'b1; mdIf.md_op = 3'd1; mdIf.rs_data = 32'h12345678; mdIf.rt_data = 32'h00000100;
      @(negedge clk);
      mdIf.start = 1'b0;
      @(negedge clk);
      check("pre-reset busy", 32'(mdIf.busy), 32'd1);
      mdIf.start = 1'b1; mdIf.md_op = 3'd4; mdIf.rs_data = 32'hDEAD;
      @(negedge clk);
      mdIf.start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset busy", 32'(mdIf.busy), 32'd0);
      check("midreset hi", mdIf.hi, 32'd0);
      check("midreset lo", mdIf.lo, 32'd0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("no late hi", mdIf.hi, 32'd0);
         check("no late lo", mdIf.lo, 32'd0);
         check("no late busy", 32'(mdIf.busy), 32'd0);
      end
      curHi = '0;
      curLo = '0;
      runOp("mt lo", 3'd5, 32'hCAFE0001, 32'd0, 32'h0, 32'hCAFE0001, 0);
      runOp("mt hi", 3'd4, 32'hBEEF0002, 32'd0, 32'hBEEF0002, 32'hCAFE0001, 0);

      // Randomized operations against the reference model.
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = 32'($urandom_range(1, 9));
            3: a = 32'hFFFFFFFF;
            default: ;
         endcase
         refModel(op, a, b, curHi, curLo, eHi, eLo, cyc);
         runOp($sformatf("rand%0d op%0d", i, op), op, a, b, eHi, eLo, cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Consumes the rs/rt operands read from the register file, after EX-stage forwarding.
- Owns the HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO as a multi-cycle operation with a busy flag.
- The hazard unit uses the busy flag to stall multiply/divide and MFHI/MFLO instructions in ID.

Parameters:
- MULT_CYCLES, 5, busy duration of MULT/MULTU in cycles (must be >= 1).
- DIV_CYCLES, 10, busy duration of DIV/DIVU in cycles (must be >= 1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only when md_op is a valid op.
- md_op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
- rs_data  in  32  forwarded rs operand (multiplicand/dividend, or MT source).
- rt_data  in  32  forwarded rt operand (multiplier/divisor).
- out_sel  in  1  0 selects LO, 1 selects HI (for MFLO/MFHI).
- md_out  out  32  combinational HI or LO, chosen by out_sel.
- busy  out  1  operation in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (posedge clk with reset=1):
  - hi=0, lo=0, busy=0, internal counter=0, pending result discarded.
  - Reset has priority over every other input, including mid-operation.
- Accept condition: start=1, busy=0, md_op in 0..3, at posedge.
  - Latch the operands and compute the 64-bit result into internal pending registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES; busy=1 from that edge.
  - Counter decrements each edge while busy.
  - On the edge where the counter goes 1 -> 0: pending result written to hi/lo and busy=0 at that same edge.
  - busy is therefore high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - hi/lo keep their old values throughout the busy window.
- MTHI/MTLO: start=1, busy=0, md_op=4/5.
  - hi (or lo) <= rs_data at the next edge.
  - busy stays 0; the other register is unchanged.
- start=1 while busy=1: ignored entirely; no restart and no MT write. The hazard unit guarantees this never occurs legally.
- md_op 6/7 with start=1: no effect.
- MULT: signed 32x32 -> 64; hi = bits [63:32], lo = bits [31:0].
- MULTU: unsigned 32x32 -> 64; same hi/lo split.
- DIV: signed division, quotient truncated toward zero.
  - lo = quotient; hi = remainder, whose sign follows the dividend.
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU: unsigned division; lo = quotient, hi = remainder.
- Divide by zero (DIV or DIVU with rt_data=0):
  - busy still asserted for DIV_CYCLES cycles.
  - hi/lo unchanged at completion.
- md_out: pure mux of the current hi/lo registers. There is no bypass of an in-flight result; MFHI/MFLO must stall while busy.
- Operand inputs may change after the accept edge without affecting the result.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFF rt=0x00000002, MULT_CYCLES=5 -> busy high exactly 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFE at the edge busy falls; hi/lo=0 before that edge.
- MULTU rs=0xFFFFFFFF rt=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7 rt=2 -> lo=3, hi=1.
- DIVU rs=5 rt=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> busy 10 cycles, hi=0x11, lo=0x22 afterward.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULT, pulse start with MTHI rs=0xDEAD at cycle 2 of busy, assert reset at cycle 3 -> MTHI ignored; after reset hi=lo=0, busy=0, no late hi/lo write; out_sel toggles md_out between lo and hi.
